// File: rtl/reorder_pkg.sv
// Shared encodings for the ping-pong reorder buffer sequencer.
package reorder_pkg;
    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR0 = 2'd1, WR1 = 2'd2, WR_WAIT = 2'd3} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD0 = 2'd1, RD1 = 2'd2} rd_state_t;

    function automatic wr_state_t wr_bank_st(input logic b);
        return b ? WR1 : WR0;
    endfunction

    function automatic rd_state_t rd_bank_st(input logic b);
        return b ? RD1 : RD0;
    endfunction
endpackage

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong bank sequencer: picks the fill and drain banks, owns bank locks, counts frames.
//  state   | meaning
//  WR_IDLE | no bank selected yet since reset
//  WRb     | bank b takes writes until full
//  WR_WAIT | next bank still locked or en low
//  RD_IDLE | waiting for bank rd_ptr to lock
//  RDb     | bank b drains until empty
module pingpong_bank_ctrl
    import reorder_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          full0,
    input  logic          full1,
    input  logic          empty0,
    input  logic          empty1,
    output logic          mem0wr_st_decode,
    output logic          mem1wr_st_decode,
    output logic          mem0rd_st_decode,
    output logic          mem1rd_st_decode,
    output logic          mem0_lock,
    output logic          mem1_lock,
    output logic [1:0]    banks_locked,
    output logic          wr_stall,
    output logic [CW-1:0] frames_written,
    output logic [CW-1:0] frames_read
);
    wr_state_t            r_wr_st, w_wr_nxt;
    rd_state_t            r_rd_st, w_rd_nxt;
    logic                 r_wr_ptr, r_rd_ptr;
    logic [NUM_BANKS-1:0] r_lock, w_lock_set, w_lock_clr;
    logic [CW-1:0]        r_frames_written, r_frames_read;

    assign w_lock_set = {(r_wr_st == WR1) && full1, (r_wr_st == WR0) && full0};
    assign w_lock_clr = {(r_rd_st == RD1) && empty1, (r_rd_st == RD0) && empty0};

    // Lock checks use the registered value, so a bank released on this edge is not reused until the next.
    always_comb begin
        w_wr_nxt = r_wr_st;
        case (r_wr_st)
            WR_IDLE: if (en) w_wr_nxt = wr_bank_st(r_wr_ptr);
            WR0:     if (full0) w_wr_nxt = (en && !r_lock[1]) ? WR1 : WR_WAIT;
            WR1:     if (full1) w_wr_nxt = (en && !r_lock[0]) ? WR0 : WR_WAIT;
            WR_WAIT: if (en && !r_lock[r_wr_ptr]) w_wr_nxt = wr_bank_st(r_wr_ptr);
            default: w_wr_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        w_rd_nxt = r_rd_st;
        case (r_rd_st)
            RD_IDLE: if (r_lock[r_rd_ptr]) w_rd_nxt = rd_bank_st(r_rd_ptr);
            RD0:     if (empty0) w_rd_nxt = RD_IDLE;
            RD1:     if (empty1) w_rd_nxt = RD_IDLE;
            default: w_rd_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_st  <= WR_IDLE;
            r_wr_ptr <= 1'b0;
        end else begin
            r_wr_st <= w_wr_nxt;
            if (|w_lock_set) r_wr_ptr <= w_lock_set[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_st  <= RD_IDLE;
            r_rd_ptr <= 1'b0;
        end else begin
            r_rd_st <= w_rd_nxt;
            if (|w_lock_clr) r_rd_ptr <= w_lock_clr[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lock <= '0;
        else        r_lock <= (r_lock | w_lock_set) & ~w_lock_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frames_written <= '0;
            r_frames_read    <= '0;
        end else begin
            if (|w_lock_set) r_frames_written <= r_frames_written + CW'(1);
            if (|w_lock_clr) r_frames_read    <= r_frames_read + CW'(1);
        end
    end

    assign mem0wr_st_decode = (r_wr_st == WR0);
    assign mem1wr_st_decode = (r_wr_st == WR1);
    assign mem0rd_st_decode = (r_rd_st == RD0);
    assign mem1rd_st_decode = (r_rd_st == RD1);
    assign mem0_lock        = r_lock[0];
    assign mem1_lock        = r_lock[1];
    assign banks_locked     = {1'b0, r_lock[0]} + {1'b0, r_lock[1]};
    assign wr_stall         = (r_wr_st == WR_WAIT);
    assign frames_written   = r_frames_written;
    assign frames_read      = r_frames_read;

    a_wr_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({mem0wr_st_decode, mem1wr_st_decode}));
    a_rd_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({mem0rd_st_decode, mem1rd_st_decode}));
    a_no_wr_rd_same: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem0wr_st_decode && mem0rd_st_decode) && !(mem1wr_st_decode && mem1rd_st_decode));
    a_no_wr_locked: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem0wr_st_decode && mem0_lock) && !(mem1wr_st_decode && mem1_lock));
endmodule
